// File: rtl/md_issue_ctrl.sv
// Issue/sequencing controller between the E stage and the multiply/divide unit.
// Registers mult/div operands, strobes the unit, stalls while it is occupied and times out stuck ops.
module md_issue_ctrl #(
  parameter int unsigned TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  output logic        stall,
  output logic        rd_valid,
  output logic [3:0]  unit_op,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic        unit_hi_we,
  output logic        unit_lo_we,
  output logic [31:0] unit_wdata,
  output logic        unit_out_sel,
  input  logic        unit_busy,
  output logic        div0,
  output logic [7:0]  op_cycles,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  // The cycle counter is one bit wider than op_cycles so the watchdog limit
  // (up to 256) is representable without wrapping.
  localparam logic [8:0] TMO_LIM = 9'(TIMEOUT + 1);

  state_e      state_q, state_d;
  logic [8:0]  cyc_q, cyc_d;
  logic [3:0]  unit_op_q, unit_op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        div0_q, div0_d;
  logic [7:0]  opc_q, opc_d;
  logic        err_q, err_d;

  logic        ready;
  logic        accept;
  logic        is_md;
  logic        div_by_zero;
  logic        issue;
  logic [3:0]  issue_code;

  function automatic logic [7:0] sat8(input logic [8:0] v);
    return (v > 9'd255) ? 8'hFF : v[7:0];
  endfunction

  function automatic logic [8:0] inc_sat(input logic [8:0] v);
    return (v == 9'h1FF) ? v : v + 9'd1;
  endfunction

  assign ready       = (state_q == IDLE) | ((state_q == WAIT) & ~unit_busy);
  assign accept      = req_valid & ready & ~flush;
  assign is_md       = ~req_op[2];
  assign div_by_zero = is_md & req_op[1] & (req_b == 32'd0);
  assign issue       = accept & is_md & ~div_by_zero;
  assign issue_code  = {1'b0, req_op[1], ~req_op[1], req_op[0]};

  assign stall        = req_valid & ~ready;
  assign rd_valid     = accept & (req_op[2:1] == 2'b11);
  assign unit_hi_we   = accept & (req_op == 3'b100);
  assign unit_lo_we   = accept & (req_op == 3'b101);
  assign unit_wdata   = req_a;
  assign unit_out_sel = req_valid & req_op[0];

  assign unit_op   = unit_op_q;
  assign unit_a    = a_q;
  assign unit_b    = b_q;
  assign div0      = div0_q;
  assign op_cycles = opc_q;
  assign err       = err_q;

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    unit_op_d = unit_op_q;
    a_d       = a_q;
    b_d       = b_q;
    opc_d     = opc_q;
    err_d     = err_q;
    div0_d    = accept & div_by_zero;

    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d   = ISSUE;
          cyc_d     = 9'd1;
          unit_op_d = issue_code;
          a_d       = req_a;
          b_d       = req_b;
        end
      end
      ISSUE: begin
        state_d   = WAIT;
        unit_op_d = 4'd0;
        cyc_d     = inc_sat(cyc_q);
      end
      WAIT: begin
        if (!unit_busy) begin
          opc_d = sat8(cyc_q);
          if (issue) begin
            state_d   = ISSUE;
            cyc_d     = 9'd1;
            unit_op_d = issue_code;
            a_d       = req_a;
            b_d       = req_b;
          end else begin
            state_d = IDLE;
          end
        end else if (cyc_q > TMO_LIM) begin
          // Abandon the stuck op; its eventual result is ignored.
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cyc_d = inc_sat(cyc_q);
        end
      end
      default: begin
        state_d   = IDLE;
        unit_op_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cyc_q     <= 9'd0;
      unit_op_q <= 4'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      div0_q    <= 1'b0;
      opc_q     <= 8'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      unit_op_q <= unit_op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      div0_q    <= div0_d;
      opc_q     <= opc_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: a simple busy-latency unit model plus a transaction-level
// reference of the issue controller (in-flight flag and age) checked every cycle.
module tb_md_issue_ctrl;

  localparam int TMO = 4;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        flush;
  logic        stall, rd_valid;
  logic [3:0]  unit_op;
  logic [31:0] unit_a, unit_b;
  logic        unit_hi_we, unit_lo_we;
  logic [31:0] unit_wdata;
  logic        unit_out_sel;
  logic        unit_busy;
  logic        div0;
  logic [7:0]  op_cycles;
  logic        err;

  int tests = 0;
  int fails = 0;

  md_issue_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(rst), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .flush(flush), .stall(stall),
    .rd_valid(rd_valid), .unit_op(unit_op), .unit_a(unit_a), .unit_b(unit_b),
    .unit_hi_we(unit_hi_we), .unit_lo_we(unit_lo_we), .unit_wdata(unit_wdata),
    .unit_out_sel(unit_out_sel), .unit_busy(unit_busy), .div0(div0),
    .op_cycles(op_cycles), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unit model: busy rises the edge after an op strobe and stays high for lat cycles.
  int lat = 2;
  bit stuck = 1'b0;
  int cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      unit_busy <= 1'b0;
      cnt       <= 0;
    end else if (unit_op != 4'd0) begin
      unit_busy <= 1'b1;
      cnt       <= lat;
    end else if (unit_busy && !stuck) begin
      if (cnt <= 1) unit_busy <= 1'b0;
      else cnt <= cnt - 1;
    end
  end

  // Reference: one op at most in flight, age counts cycles since acceptance.
  bit          m_inflight;
  int          m_age;
  logic [3:0]  m_code;
  logic [31:0] m_a, m_b;
  logic        m_div0;
  int          m_opc;
  logic        m_err;

  logic        s_stall, s_rd, s_sel, s_hiwe, s_div0, s_err;
  logic [3:0]  s_op;
  logic [31:0] s_a, s_b, s_wdata;
  logic [7:0]  s_opc;

  int n_stall, ops_seen;
  logic       hold;
  logic [2:0] r_op;
  logic [31:0] r_a, r_b;
  logic       r_v, r_fl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_inflight = 1'b0; m_age = 0; m_code = 4'd0; m_a = 32'd0; m_b = 32'd0;
    m_div0 = 1'b0; m_opc = 0; m_err = 1'b0;
  endtask

  task automatic step(input logic v, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic fl);
    logic rdy, acc, dz;
    logic [3:0] e_op;
    req_valid = v; req_op = op; req_a = a; req_b = b; flush = fl;
    @(negedge clk);
    rdy  = !m_inflight || (m_age >= 2 && !unit_busy);
    acc  = v && rdy && !fl;
    dz   = !op[2] && op[1] && (b == 32'd0);
    e_op = (m_inflight && m_age == 1) ? m_code : 4'd0;
    chk("stall",    32'(stall),        32'(v && !rdy));
    chk("rd_valid", 32'(rd_valid),     32'(acc && op[2] && op[1]));
    chk("hi_we",    32'(unit_hi_we),   32'(acc && op == 3'b100));
    chk("lo_we",    32'(unit_lo_we),   32'(acc && op == 3'b101));
    chk("wdata",    unit_wdata,        a);
    chk("out_sel",  32'(unit_out_sel), 32'(v && op[0]));
    chk("unit_op",  32'(unit_op),      32'(e_op));
    chk("unit_a",   unit_a,            m_a);
    chk("unit_b",   unit_b,            m_b);
    chk("div0",     32'(div0),         32'(m_div0));
    chk("op_cyc",   32'(op_cycles),    32'(m_opc));
    chk("err",      32'(err),          32'(m_err));
    s_stall = stall; s_rd = rd_valid; s_sel = unit_out_sel; s_hiwe = unit_hi_we;
    s_div0 = div0; s_err = err; s_op = unit_op; s_a = unit_a; s_b = unit_b;
    s_wdata = unit_wdata; s_opc = op_cycles;
    if (m_inflight) begin
      if (m_age >= 2 && !unit_busy) begin
        m_opc = (m_age > 255) ? 255 : m_age;
        m_inflight = 1'b0;
      end else if (m_age >= 2 && m_age > TMO + 1) begin
        m_err = 1'b1;
        m_inflight = 1'b0;
      end else begin
        m_age++;
      end
    end
    m_div0 = acc && dz;
    if (acc && !op[2] && !dz) begin
      m_inflight = 1'b1;
      m_age  = 1;
      m_code = op[1] ? {3'b010, op[0]} : {3'b001, op[0]};
      m_a = a;
      m_b = b;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_a = 32'd0; req_b = 32'd0; flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_unit_op", 32'(unit_op), 32'd0);
    chk("rst_err",     32'(err),     32'd0);
    chk("rst_stall",   32'(stall),   32'd0);
    chk("rst_rd",      32'(rd_valid), 32'd0);
    rst = 1'b0;

    // MULT 7 * -3, unit busy 2 cycles, dependent MFLO
    lat = 2;
    step(1'b1, 3'b000, 32'd7, 32'hFFFF_FFFD, 1'b0);
    chk("mult_no_stall", 32'(s_stall), 32'd0);
    n_stall = 0; ops_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 3'b111, 32'd0, 32'd0, 1'b0);
      if (s_op != 4'd0) ops_seen++;
      if (i == 0) begin
        chk("mult_op", 32'(s_op), 32'h2);
        chk("mult_a",  s_a, 32'd7);
        chk("mult_b",  s_b, 32'hFFFF_FFFD);
      end
      if (!s_stall) break;
      n_stall++;
    end
    chk("mflo_stalls", 32'(n_stall), 32'd3);
    chk("mult_op_1cyc", 32'(ops_seen), 32'd1);
    chk("mflo_rd", 32'(s_rd), 32'd1);
    chk("mflo_sel", 32'(s_sel), 32'd1);
    step(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    chk("mult_opcyc", 32'(s_opc), 32'd4);

    // DIVU by zero, then MFHI
    step(1'b1, 3'b011, 32'd100, 32'd0, 1'b0);
    chk("dz_no_stall", 32'(s_stall), 32'd0);
    step(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    chk("dz_pulse", 32'(s_div0), 32'd1);
    chk("dz_no_op", 32'(s_op), 32'd0);
    step(1'b1, 3'b110, 32'd0, 32'd0, 1'b0);
    chk("mfhi_no_stall", 32'(s_stall), 32'd0);
    chk("mfhi_rd", 32'(s_rd), 32'd1);
    chk("dz_pulse_end", 32'(s_div0), 32'd0);

    // MTHI idle, then MTHI during WAIT
    step(1'b1, 3'b100, 32'h1234, 32'd0, 1'b0);
    chk("mthi_we", 32'(s_hiwe), 32'd1);
    chk("mthi_wdata", s_wdata, 32'h1234);
    lat = 3;
    step(1'b1, 3'b000, 32'd5, 32'd6, 1'b0);
    n_stall = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 3'b100, 32'h1234, 32'd0, 1'b0);
      if (!s_stall) break;
      n_stall++;
    end
    chk("mthi_stalls", 32'(n_stall), 32'd4);
    chk("mthi_late_we", 32'(s_hiwe), 32'd1);

    // Back-to-back DIV, then flushed DIV
    lat = 2;
    step(1'b1, 3'b010, 32'd50, 32'd7, 1'b0);
    n_stall = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 3'b010, 32'd9, 32'd3, 1'b0);
      if (!s_stall) break;
      n_stall++;
    end
    chk("div2_stalls", 32'(n_stall), 32'd3);
    step(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    chk("div2_issue", 32'(s_op), 32'h4);
    chk("div2_a", s_a, 32'd9);
    step(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    step(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    step(1'b1, 3'b010, 32'd8, 32'd2, 1'b1);
    chk("flush_no_stall", 32'(s_stall), 32'd0);
    step(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    chk("flush_no_op", 32'(s_op), 32'd0);
    chk("flush_a", s_a, 32'd9);
    chk("flush_opcyc", 32'(s_opc), 32'd4);
    step(1'b1, 3'b111, 32'd0, 32'd0, 1'b0);
    chk("flush_idle", 32'(s_stall), 32'd0);

    // Watchdog with busy stuck high
    stuck = 1'b1;
    step(1'b1, 3'b001, 32'd1, 32'd2, 1'b0);
    n_stall = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 3'b110, 32'd0, 32'd0, 1'b0);
      if (!s_stall) break;
      n_stall++;
    end
    chk("tmo_stalls", 32'(n_stall), 32'd6);
    chk("tmo_err", 32'(s_err), 32'd1);
    chk("tmo_rd", 32'(s_rd), 32'd1);
    repeat (2) step(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    chk("err_sticky", 32'(s_err), 32'd1);

    // Asynchronous reset mid-WAIT
    step(1'b1, 3'b000, 32'd3, 32'd4, 1'b0);
    chk("post_err_accept", 32'(s_stall), 32'd0);
    step(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    step(1'b1, 3'b111, 32'd0, 32'd0, 1'b0);
    req_valid = 1'b1; req_op = 3'b111;
    rst = 1'b1;
    #2;
    chk("arst_op",    32'(unit_op),   32'd0);
    chk("arst_a",     unit_a,         32'd0);
    chk("arst_b",     unit_b,         32'd0);
    chk("arst_opcyc", 32'(op_cycles), 32'd0);
    chk("arst_err",   32'(err),       32'd0);
    chk("arst_div0",  32'(div0),      32'd0);
    chk("arst_stall", 32'(stall),     32'd0);
    req_valid = 1'b0;
    model_reset();
    stuck = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    lat = 2;
    step(1'b1, 3'b000, 32'd11, 32'd12, 1'b0);
    chk("rst_mult_accept", 32'(s_stall), 32'd0);
    step(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    chk("rst_mult_op", 32'(s_op), 32'h2);
    chk("rst_mult_a", s_a, 32'd11);

    // Randomized traffic, request held stable while stalled
    hold = 1'b0; r_v = 1'b0; r_op = 3'd0; r_a = 32'd0; r_b = 32'd0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        r_v  = ($urandom_range(0, 3) != 0);
        r_op = 3'($urandom_range(0, 7));
        r_a  = $urandom;
        r_b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      end
      r_fl = ($urandom_range(0, 15) == 0);
      lat  = $urandom_range(1, 5);
      step(r_v, r_op, r_a, r_b, r_fl);
      hold = s_stall && !r_fl;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
